iic_adc_sched: RTL

IIC_ADC_SCHED -- requirements
Module: iic_adc_sched

---
 rtl/iic_adc_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/iic_adc_sched.sv
// IIC ADC scheduler: one config write after power-up, then periodic reads.
// Optional watchdog on stuck transactions when IIC_TIMEOUT_EN is defined.
module iic_adc_sched #(
  parameter int         INIT_DLY  = 500,
  parameter int         PERIOD    = 12000,
  parameter logic [7:0] CFG_BYTE  = 8'h84,
  parameter int         MAX_RETRY = 3,
  parameter int         TIMEOUT   = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        m_wr_req,
  output logic        m_rd_req,
  output logic [7:0]  m_cfg_data,
  input  logic        m_done,
  input  logic        m_ack_err,
  input  logic [15:0] m_ad_voltage,
  output logic [15:0] ad_voltage_valid,
  output logic        sample_vld,
  output logic        fault,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] INIT_WAIT = 3'd0;
  localparam logic [2:0] CFG       = 3'd1;
  localparam logic [2:0] RUN_WAIT  = 3'd2;
  localparam logic [2:0] RD        = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  logic [2:0]  state;
  logic [31:0] cnt;
  logic [31:0] pcnt;
  logic [7:0]  rcnt;
  logic        busy;
  logic        tick;
  logic        tmo;
  logic        ok;
  logic        bad;
  logic        last;

  assign busy = m_wr_req | m_rd_req;
  assign tick = (pcnt == 32'(PERIOD - 1));
  assign last = ({24'd0, rcnt} == 32'(MAX_RETRY - 1));

`ifdef IIC_TIMEOUT_EN
  logic [31:0] wd;

  assign tmo = busy & (wd == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (busy && !(ok || bad)) begin
      wd <= wd + 32'd1;
    end else begin
      wd <= '0;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^32'(TIMEOUT);
  assign tmo = 1'b0;
`endif

  // m_done wins over a watchdog expiry in the same cycle
  assign ok  = busy & m_done & ~m_ack_err;
  assign bad = busy & ((m_done & m_ack_err) | (~m_done & tmo));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= INIT_WAIT;
      cnt              <= '0;
      pcnt             <= '0;
      rcnt             <= '0;
      m_wr_req         <= 1'b0;
      m_rd_req         <= 1'b0;
      m_cfg_data       <= CFG_BYTE;
      ad_voltage_valid <= '0;
      sample_vld       <= 1'b0;
      fault            <= 1'b0;
      err_cnt          <= '0;
    end else begin
      sample_vld <= 1'b0;
      if (state == RUN_WAIT || state == RD) begin
        pcnt <= tick ? '0 : pcnt + 32'd1;
      end
      if (bad) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        rcnt <= rcnt + 8'd1;
      end
      unique case (state)
        INIT_WAIT: begin
          if (cnt == 32'(INIT_DLY - 1)) begin
            state      <= CFG;
            cnt        <= '0;
            m_wr_req   <= 1'b1;
            m_cfg_data <= CFG_BYTE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CFG: begin
          if (ok) begin
            m_wr_req <= 1'b0;
            rcnt     <= '0;
            pcnt     <= '0;
            state    <= RUN_WAIT;
          end else if (bad) begin
            m_wr_req <= 1'b0;
            if (last) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (!m_wr_req) begin
            m_wr_req <= 1'b1;
          end
        end
        RUN_WAIT: begin
          if (tick) begin
            state    <= RD;
            m_rd_req <= 1'b1;
          end
        end
        RD: begin
          if (ok) begin
            m_rd_req <= 1'b0;
            rcnt     <= '0;
            state    <= RUN_WAIT;
            if (m_ad_voltage != 16'd0) begin
              ad_voltage_valid <= m_ad_voltage;
              sample_vld       <= 1'b1;
            end
          end else if (bad) begin
            m_rd_req <= 1'b0;
            if (last) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= RUN_WAIT;
            end
          end
        end
        FAULT: begin
          m_wr_req <= 1'b0;
          m_rd_req <= 1'b0;
          fault    <= 1'b1;
        end
        default: begin
          state    <= FAULT;
          m_wr_req <= 1'b0;
          m_rd_req <= 1'b0;
          fault    <= 1'b1;
        end
      endcase
    end
  end

endmodule
